// File: rtl/dcache_dm_if.sv
// Load/store-unit request/response and backing-memory bus for dcache_dm.
// slave is the cache's view; master is the issue stage plus memory.
interface dcache_dm_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 6
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [TAG_W-1:0]  req_tag;
   logic              resp_valid;
   logic [TAG_W-1:0]  resp_tag;
   logic [DATA_W-1:0] resp_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_tag, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_tag, resp_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_tag, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_tag, resp_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one
// outstanding request; the instruction tag rides through to the response.
module dcache_dm #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TAG_W   = 6,
   parameter int unsigned INDEX_W = 6,
   parameter int unsigned OFF_W   = 2
) (
   input logic       clk,
   input logic       rst_n,
   dcache_dm_if.slave bus
);
   localparam int unsigned LINES = 2 ** INDEX_W;
   localparam int unsigned WORDS = 2 ** OFF_W;
   localparam int unsigned CT_W  = ADDR_W - INDEX_W - OFF_W;
   localparam int unsigned LA_W  = INDEX_W + OFF_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_wen;
   logic [TAG_W-1:0]    r_tag;
   logic [OFF_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_result;
   logic [LINES-1:0]    r_valid;
   logic [CT_W-1:0]     r_tags [LINES];
   logic [DATA_W-1:0]   r_data [LINES*WORDS];
   logic [DATA_W-1:0]   r_rd_word;

   logic                r_req_ready;
   logic                r_resp_valid;
   logic [TAG_W-1:0]    r_resp_tag;
   logic [DATA_W-1:0]   r_resp_rdata;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic [OFF_W-1:0]    w_off;
   logic [INDEX_W-1:0]  w_idx;
   logic [CT_W-1:0]     w_ctag;
   logic                w_hit;
   logic                w_fill_ack;
   logic                w_last;
   logic                w_arr_we;
   logic [LA_W-1:0]     w_arr_waddr;
   logic [DATA_W-1:0]   w_arr_wdata;

   assign w_off       = r_addr[OFF_W-1:0];
   assign w_idx       = r_addr[LA_W-1:OFF_W];
   assign w_ctag      = r_addr[ADDR_W-1:LA_W];
   assign w_hit       = r_valid[w_idx] && (r_tags[w_idx] == w_ctag);
   assign w_fill_ack  = (r_state == S_FILL) && bus.mem_ack;
   assign w_last      = (r_cnt == OFF_W'(WORDS - 1));
   assign w_arr_we    = ((r_state == S_LOOKUP) && r_wen && w_hit) || w_fill_ack;
   assign w_arr_waddr = (r_state == S_FILL) ? {w_idx, r_cnt} : r_addr[LA_W-1:0];
   assign w_arr_wdata = (r_state == S_FILL) ? bus.mem_rdata : r_wdata;

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_tag   = r_resp_tag;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;

   // Data/tag storage; the word is read at handshake so it is ready in LOOKUP.
   always_ff @(posedge clk) begin
      if (w_arr_we) begin
         r_data[w_arr_waddr] <= w_arr_wdata;
      end
      if (w_fill_ack && w_last) begin
         r_tags[w_idx] <= w_ctag;
      end
      r_rd_word <= r_data[bus.req_addr[LA_W-1:0]];
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wen        <= 1'b0;
         r_tag        <= '0;
         r_cnt        <= '0;
         r_result     <= '0;
         r_valid      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_tag   <= '0;
         r_resp_rdata <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_addr      <= bus.req_addr;
                  r_wdata     <= bus.req_wdata;
                  r_wen       <= bus.req_wen;
                  r_tag       <= bus.req_tag;
                  r_req_ready <= 1'b0;
                  r_state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (r_wen) begin
                  r_result    <= '0;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_addr;
                  r_mem_wdata <= r_wdata;
                  r_state     <= S_WRITE;
               end else if (w_hit) begin
                  r_result <= r_rd_word;
                  r_state  <= S_RESP;
               end else begin
                  r_cnt      <= '0;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                  r_state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (bus.mem_ack) begin
                  if (r_cnt == w_off) begin
                     r_result <= bus.mem_rdata;
                  end
                  // Line becomes valid only once every word has landed.
                  if (w_last) begin
                     r_valid[w_idx] <= 1'b1;
                     r_mem_req      <= 1'b0;
                     r_state        <= S_RESP;
                  end else begin
                     r_cnt      <= r_cnt + OFF_W'(1);
                     r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], r_cnt + OFF_W'(1)};
                  end
               end
            end
            S_WRITE: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_state   <= S_RESP;
               end
            end
            S_RESP: begin
               r_resp_valid <= 1'b1;
               r_resp_tag   <= r_tag;
               r_resp_rdata <= r_result;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed vector table, mid-fill reset sequence and
// randomized traffic against a word-level cache/memory model.
module tb_dcache_dm;
   logic clk;
   logic rst_n;

   dcache_dm_if #(.ADDR_W(16), .DATA_W(32), .TAG_W(6)) bus ();

   dcache_dm #(
      .ADDR_W(16), .DATA_W(32), .TAG_W(6), .INDEX_W(6), .OFF_W(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
   } memop_t;

   typedef struct {
      bit          wen;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [5:0]  tag;
      bit          exp_hit;
      logic [31:0] exp_rdata;
      int          exp_cyc;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] bmem    [65536];
   logic [31:0] ref_mem [65536];
   bit          mv      [64];
   logic [7:0]  mt      [64];

   memop_t mem_log [$];
   int     lat_log [$];
   bit     req_seen;
   int     lat_mode;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   // Backing memory: acks each word after a chosen latency, applies writes at ack.
   initial begin : responder
      int          wait_cnt;
      int          cur_lat;
      logic        h_we;
      logic [15:0] h_addr;
      logic [31:0] h_wdata;
      wait_cnt = 0;
      cur_lat  = 1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (!bus.mem_req) begin
            wait_cnt = 0;
         end else begin
            req_seen = 1'b1;
            if (wait_cnt == 0) begin
               cur_lat = (lat_mode != 0) ? int'($urandom_range(1, 3)) : 1;
               h_we    = bus.mem_we;
               h_addr  = bus.mem_addr;
               h_wdata = bus.mem_wdata;
            end else begin
               check("mem_hold_addr", 32'(bus.mem_addr), 32'(h_addr));
               check("mem_hold_we", 32'(bus.mem_we), 32'(h_we));
               if (h_we) check("mem_hold_wdata", bus.mem_wdata, h_wdata);
            end
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_we) begin
                  bmem[bus.mem_addr] = bus.mem_wdata;
                  bus.mem_rdata = '0;
               end else begin
                  bus.mem_rdata = bmem[bus.mem_addr];
               end
               mem_log.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
               lat_log.push_back(cur_lat);
               wait_cnt = 0;
            end
         end
      end
   end

   initial begin : hang_guard
      #3000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timed out");
   end

   task automatic check_reset_vals(input string name);
      check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
      check({name, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({name, " resp_tag"}, 32'(bus.resp_tag), 32'd0);
      check({name, " resp_rdata"}, bus.resp_rdata, 32'd0);
      check({name, " mem_req"}, 32'(bus.mem_req), 32'd0);
      check({name, " mem_we"}, 32'(bus.mem_we), 32'd0);
      check({name, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({name, " mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One request end to end; exp_cyc < 0 means 3 + sum of observed ack latencies.
   task automatic run_txn(input string name, input bit wen, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [5:0] tag,
                          input bit exp_hit, input logic [31:0] exp_rdata, input int exp_cyc);
      bit          got;
      int          cyc;
      int          lat_sum;
      int          want_cyc;
      logic [31:0] rd;
      logic [5:0]  rt;
      logic        rdy;
      int          k;
      @(negedge clk);
      k = 0;
      while (!bus.req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check({name, " req_ready_before"}, 32'(bus.req_ready), 32'd1);
      mem_log.delete();
      lat_log.delete();
      req_seen = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_wen   = wen;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_tag   = tag;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      got = 1'b0; cyc = 0; rd = '0; rt = '0; rdy = 1'b0;
      for (int j = 1; j <= 300 && !got; j++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            got = 1'b1;
            cyc = j;
            rd  = bus.resp_rdata;
            rt  = bus.resp_tag;
            rdy = bus.req_ready;
         end
      end
      check({name, " resp_seen"}, 32'(got), 32'd1);
      if (got) begin
         lat_sum = 0;
         foreach (lat_log[i]) lat_sum += lat_log[i];
         want_cyc = (exp_cyc >= 0) ? exp_cyc : 3 + lat_sum;
         check({name, " rdata"}, rd, exp_rdata);
         check({name, " resp_tag"}, 32'(rt), 32'(tag));
         check({name, " latency"}, 32'(cyc), 32'(want_cyc));
         check({name, " ready_at_resp"}, 32'(rdy), 32'd1);
         @(negedge clk);
         check({name, " pulse_width"}, 32'(bus.resp_valid), 32'd0);
      end
      if (wen) begin
         check({name, " mem_ops"}, 32'(mem_log.size()), 32'd1);
         if (mem_log.size() >= 1) begin
            check({name, " wr_we"}, 32'(mem_log[0].we), 32'd1);
            check({name, " wr_addr"}, 32'(mem_log[0].addr), 32'(addr));
            check({name, " wr_data"}, mem_log[0].wdata, wdata);
         end
      end else if (exp_hit) begin
         check({name, " hit_mem_ops"}, 32'(mem_log.size()), 32'd0);
         check({name, " hit_mem_req"}, 32'(req_seen), 32'd0);
      end else begin
         check({name, " fill_ops"}, 32'(mem_log.size()), 32'd4);
         for (int i = 0; i < mem_log.size() && i < 4; i++) begin
            check({name, " fill_addr"}, 32'(mem_log[i].addr), 32'({addr[15:2], 2'(i)}));
            check({name, " fill_we"}, 32'(mem_log[i].we), 32'd0);
         end
      end
   endtask

   vec_t vecs [9];

   initial begin : main
      int          k;
      int          resp_cnt;
      bit          wen;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [5:0]  tag;
      logic [5:0]  idx;
      logic [7:0]  ct;
      bit          exp_hit;

      rst_n = 1'b0;
      lat_mode = 0;
      req_seen = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wen   = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_tag   = '0;
      for (int i = 0; i < 65536; i++) bmem[i] = 32'(i) + 32'h1000;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // wen, addr, wdata, tag, hit, rdata, cycles (all ack latencies = 1)
      vecs[0] = '{1'b0, 16'h0005, 32'h0,        6'h2A, 1'b0, 32'h0000_1005, 7};
      vecs[1] = '{1'b0, 16'h0006, 32'h0,        6'h11, 1'b1, 32'h0000_1006, 3};
      vecs[2] = '{1'b1, 16'h0006, 32'hDEADBEEF, 6'h05, 1'b0, 32'h0,         4};
      vecs[3] = '{1'b0, 16'h0006, 32'h0,        6'h06, 1'b1, 32'hDEADBEEF,  3};
      vecs[4] = '{1'b1, 16'h0100, 32'h12345678, 6'h07, 1'b0, 32'h0,         4};
      vecs[5] = '{1'b0, 16'h0100, 32'h0,        6'h08, 1'b0, 32'h12345678,  7};
      vecs[6] = '{1'b0, 16'h0105, 32'h0,        6'h09, 1'b0, 32'h0000_1105, 7};
      vecs[7] = '{1'b0, 16'h0005, 32'h0,        6'h0A, 1'b0, 32'h0000_1005, 7};
      vecs[8] = '{1'b0, 16'h0007, 32'h0,        6'h0B, 1'b1, 32'h0000_1007, 3};
      for (int v = 0; v < 9; v++) begin
         run_txn($sformatf("vec%0d", v), vecs[v].wen, vecs[v].addr, vecs[v].wdata,
                 vecs[v].tag, vecs[v].exp_hit, vecs[v].exp_rdata, vecs[v].exp_cyc);
      end

      // Reset after the second fill ack, then reload the same address.
      do_reset();
      @(negedge clk);
      mem_log.delete();
      bus.req_valid = 1'b1;
      bus.req_wen   = 1'b0;
      bus.req_addr  = 16'h0005;
      bus.req_tag   = 6'h3F;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      k = 0;
      while (mem_log.size() < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("midfill two_acks", 32'(mem_log.size() >= 2), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midfill_reset");
      rst_n = 1'b1;
      resp_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.resp_valid) resp_cnt++;
      end
      check("midfill no_resp", 32'(resp_cnt), 32'd0);
      run_txn("reload", 1'b0, 16'h0005, 32'h0, 6'h15, 1'b0, 32'h0000_1005, 7);

      // Randomized traffic on a small address pool to force hits and aliasing.
      do_reset();
      for (int i = 0; i < 65536; i++) ref_mem[i] = bmem[i];
      for (int i = 0; i < 64; i++) begin
         mv[i] = 1'b0;
         mt[i] = '0;
      end
      lat_mode = 1;
      for (int t = 0; t < 250; t++) begin
         wen   = ($urandom_range(0, 9) < 3);
         addr  = {8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         wdata = $urandom;
         tag   = 6'($urandom);
         idx   = addr[7:2];
         ct    = addr[15:8];
         exp_hit = !wen && mv[idx] && (mt[idx] == ct);
         run_txn($sformatf("rnd%0d", t), wen, addr, wdata, tag, exp_hit,
                 wen ? 32'h0 : ref_mem[addr], -1);
         if (wen) begin
            ref_mem[addr] = wdata;
         end else if (!exp_hit) begin
            mv[idx] = 1'b1;
            mt[idx] = ct;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
